// File: rtl/line_window_buffer.sv
// Multi-line window buffer: keeps the last KERNEL_H-1 lines in line memories and
// emits one vertical KERNEL_H-pixel column per accepted pixel once the frame is primed.

module line_mem #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  // Asynchronous read gives the pre-write value in the accept cycle.
  assign rdata = mem[addr];
endmodule

module line_window_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 854,
  parameter int KERNEL_H   = 3,
  parameter int KERNEL_W   = 3,
  localparam int CW        = $clog2(MAX_WIDTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CW-1:0]                  cfg_width,
  input  logic [15:0]                    cfg_height,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [KERNEL_H*DATA_WIDTH-1:0] m_col,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_border,
  output logic                           m_last,
  output logic                           frame_done
);
  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int NL = KERNEL_H - 1;

  typedef enum logic {PRIME, STREAM} state_t;

  state_t                                 state, state_nxt;
  logic [CW-1:0]                          col, w_lat, eff_w;
  logic [15:0]                            row, h_lat, eff_h;
  logic                                   accept, first_px, eol, eof, emit;
  logic [NL-1:0][DATA_WIDTH-1:0]          rd, wd;
  logic [KERNEL_H-1:0][DATA_WIDTH-1:0]    col_d, col_q;

  assign s_ready  = !m_valid || m_ready;
  assign accept   = s_valid && s_ready;
  assign first_px = (col == '0) && (row == '0);
  // Geometry is taken live from cfg_* on the first pixel, latched copy afterwards.
  assign eff_w    = first_px ? cfg_width  : w_lat;
  assign eff_h    = first_px ? cfg_height : h_lat;
  assign eol      = (col == eff_w - CW'(1));
  assign eof      = eol && (row == eff_h - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col   <= '0;
      row   <= '0;
      w_lat <= '0;
      h_lat <= '0;
    end else if (accept) begin
      if (first_px) begin
        w_lat <= cfg_width;
        h_lat <= cfg_height;
      end
      if (eol) begin
        col <= '0;
        row <= eof ? 16'd0 : row + 16'd1;
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line k is shifted into line k+1 at the same column; line 0 takes the new pixel.
  for (genvar k = 0; k < NL; k++) begin : g_line
    if (k == 0) begin : g_head
      assign wd[k] = s_data;
    end else begin : g_tail
      assign wd[k] = rd[k-1];
    end
    line_mem #(.DW(DATA_WIDTH), .DEPTH(MAX_WIDTH), .AW(AW)) u_line (
      .clk   (clk),
      .we    (accept),
      .addr  (col[AW-1:0]),
      .wdata (wd[k]),
      .rdata (rd[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PRIME;
    else     state <= state_nxt;
  end

  // End of frame wins over priming so short frames never leave PRIME.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (eof)
        state_nxt = PRIME;
      else if (state == PRIME && eol && row == 16'(KERNEL_H - 2))
        state_nxt = STREAM;
    end
  end

  always_comb begin
    emit = accept && (state == STREAM);
  end

  always_comb begin
    col_d = '0;
    col_d[KERNEL_H-1] = s_data;
    for (int j = 0; j < NL; j++) col_d[NL-1-j] = rd[j];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid    <= 1'b0;
      col_q      <= '0;
      m_border   <= 1'b0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && eof;
      if (emit) begin
        m_valid  <= 1'b1;
        col_q    <= col_d;
        m_border <= int'(col) < KERNEL_W - 1;
        m_last   <= eof;
      end else if (m_ready) begin
        m_valid  <= 1'b0;
      end
    end
  end

  assign m_col = col_q;
endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer: directed frame scenarios plus random traffic,
// checked against a frame-image reference model.

module tb_line_window_buffer;
  localparam int DW = 8, MW = 16, KH = 3, KW = 3, CW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [CW-1:0]   cfg_width;
  logic [15:0]     cfg_height;
  logic [DW-1:0]   s_data;
  logic            s_valid, s_ready;
  logic [KH*DW-1:0] m_col;
  logic            m_valid, m_ready, m_border, m_last, frame_done;

  always #5 clk = ~clk;

  line_window_buffer #(.DATA_WIDTH(DW), .MAX_WIDTH(MW), .KERNEL_H(KH), .KERNEL_W(KW)) dut (
    .clk(clk), .rst(rst), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_col(m_col), .m_valid(m_valid), .m_ready(m_ready),
    .m_border(m_border), .m_last(m_last), .frame_done(frame_done)
  );

  int n_chk = 0, n_fail = 0;

  // Reference model: a full image of the current frame, indexed by (row, col).
  logic [7:0]  img [0:63][0:15];
  bit          e_valid, e_border, e_last, e_done;
  logic [23:0] e_col;
  int          mc, mr, mw, mh;
  int          nxt_w, nxt_h;
  int          taken, done_cnt, dut_done;
  logic [23:0] first_taken, last_taken;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_valid = 0; e_border = 0; e_last = 0; e_done = 0; e_col = '0;
    mc = 0; mr = 0;
  endtask

  task automatic cyc(input bit sv, input logic [7:0] d, input bit mrdy, output bit acc);
    @(negedge clk);
    chk("m_valid", 32'(m_valid), 32'(e_valid));
    chk("m_col", 32'(m_col), 32'(e_col));
    chk("m_border", 32'(m_border), 32'(e_border));
    chk("m_last", 32'(m_last), 32'(e_last));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    if (frame_done) dut_done++;
    cfg_width = CW'(nxt_w); cfg_height = 16'(nxt_h);
    s_valid = sv; s_data = d; m_ready = mrdy;
    #1;
    acc = sv && (!e_valid || mrdy);
    chk("s_ready", 32'(s_ready), 32'(!e_valid || mrdy));
    @(posedge clk);
    if (e_valid && mrdy) begin
      taken++;
      if (taken == 1) first_taken = e_col;
      last_taken = e_col;
    end
    e_done = 0;
    if (acc) begin
      if (mc == 0 && mr == 0) begin
        mw = nxt_w; mh = nxt_h;
        chk("cfg_legal", 32'(mw >= 1 && mw <= MW), 32'd1);
      end
      img[mr][mc] = d;
      if (mr >= KH - 1) begin
        e_valid  = 1;
        e_col    = {d, img[mr-1][mc], img[mr-2][mc]};
        e_border = mc < KW - 1;
        e_last   = (mc == mw - 1) && (mr == mh - 1);
      end else if (mrdy) e_valid = 0;
      if (mc == mw - 1) begin
        mc = 0;
        if (mr == mh - 1) begin mr = 0; e_done = 1; done_cnt++; end
        else mr++;
      end else mc++;
    end else if (mrdy) e_valid = 0;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) cyc(1'b0, 8'h00, 1'b1, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_valid = 0; rst = 1;
    #2;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_col", 32'(m_col), 32'd0);
    chk("rst_m_border", 32'(m_border), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic frame(input int w, input int h, input logic [7:0] base, input int pv, input int pr,
                       input int stall_at = -1, input int chg_idx = -1, input int chg_w = 0,
                       input int npx = -1);
    int total, sent, budget, stall;
    bit sv, mrdy, acc;
    logic [7:0] d;
    total = (npx < 0) ? w * h : npx;
    sent = 0; budget = 0; stall = 5;
    nxt_w = w; nxt_h = h;
    while (sent < total) begin
      if (sent == chg_idx) nxt_w = chg_w;
      sv   = ($urandom_range(99) < pv);
      mrdy = ($urandom_range(99) < pr);
      if (stall_at >= 0 && taken == stall_at && e_valid && stall > 0) begin
        mrdy = 0; stall--;
      end
      d = base + 8'((sent / w) * 16 + sent % w);
      cyc(sv, d, mrdy, acc);
      if (acc) sent++;
      budget++;
      if (budget > 20000) begin
        chk("frame_budget", 32'(sent), 32'(total));
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; s_valid = 0; s_data = 0; m_ready = 1;
    nxt_w = 4; nxt_h = 4; cfg_width = 4; cfg_height = 4;
    taken = 0; done_cnt = 0; dut_done = 0;
    model_reset();
    do_reset();

    // Basic 4x4 frame, free-flowing
    taken = 0;
    frame(4, 4, 8'h00, 100, 100);
    idle(3);
    chk("f1_outputs", 32'(taken), 32'd8);
    chk("f1_first", 32'(first_taken), 32'h201000);
    chk("f1_last", 32'(last_taken), 32'h332313);

    // Downstream stall on the third column
    taken = 0;
    frame(4, 4, 8'h00, 100, 100, 2);
    idle(3);
    chk("stall_outputs", 32'(taken), 32'd8);

    // Back-to-back frames, second offset by 0x80
    taken = 0;
    frame(4, 4, 8'h00, 100, 100);
    frame(4, 4, 8'h80, 100, 100);
    idle(3);
    chk("b2b_outputs", 32'(taken), 32'd16);
    chk("b2b_last", 32'(last_taken), 32'hB3A393);

    // Frame shorter than the kernel: primes only
    taken = 0;
    frame(4, 2, 8'h00, 100, 100);
    idle(3);
    chk("short_outputs", 32'(taken), 32'd0);

    // Width change mid-frame only takes effect on the next frame
    taken = 0;
    frame(4, 3, 8'h00, 100, 100, -1, 5, 6);
    idle(2);
    chk("chg_outputs_w4", 32'(taken), 32'd4);
    taken = 0;
    frame(6, 3, 8'h00, 100, 100);
    idle(2);
    chk("chg_outputs_w6", 32'(taken), 32'd6);

    // Reset while streaming row 3, then a fresh frame
    frame(4, 4, 8'h00, 100, 100, -1, -1, 0, 13);
    do_reset();
    taken = 0;
    frame(4, 4, 8'h40, 100, 100);
    idle(3);
    chk("post_rst_outputs", 32'(taken), 32'd8);
    chk("post_rst_first", 32'(first_taken), 32'h605040);

    // Random geometries and handshake traffic
    for (int i = 0; i < 8; i++) begin
      frame($urandom_range(16, 1), $urandom_range(8, 1), 8'($urandom_range(255)),
            $urandom_range(100, 50), $urandom_range(100, 30));
    end
    idle(4);
    chk("frame_done_total", 32'(dut_done), 32'(done_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
